// File: rtl/pc_pkg.sv
// pc_pkg: shared definitions for the program-counter unit.
//   state_t        : FSM state encoding (BOOT/RUN/HALT; 2'd3 is unused)
//   PH_N_DEF       : default phase one-hot width
//   STEP_DEF       : default sequential increment / alignment unit
//   RESET_VEC_DEF  : default pc value at reset
//   TRAP_VEC_DEF   : default trap / fault entry address
package pc_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam int unsigned PH_N_DEF      = 5;
    localparam int unsigned STEP_DEF      = 4;
    localparam logic [31:0] RESET_VEC_DEF = 32'h0000_0000;
    localparam logic [31:0] TRAP_VEC_DEF  = 32'h0000_0100;

endpackage

// File: rtl/pc_next_sel.sv
// pc_next_sel: combinational next-pc / next-epc selection.
//   Inputs : pc, epc (current registers), dr (transfer target),
//            trap, eret, ct_taken (update requests)
//   Outputs: pc_next, epc_next (values to load on an update event),
//            fault (misaligned control transfer selected)
// Priority: trap > eret > ct_taken > sequential.
module pc_next_sel
    import pc_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     STEP     = STEP_DEF,
    parameter logic [XLEN-1:0] TRAP_VEC = XLEN'(TRAP_VEC_DEF)
) (
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] epc,
    input  logic [XLEN-1:0] dr,
    input  logic            trap,
    input  logic            eret,
    input  logic            ct_taken,
    output logic [XLEN-1:0] pc_next,
    output logic [XLEN-1:0] epc_next,
    output logic            fault
);

    logic misaligned;

    // STEP is a power of two, so the low bits below it must be zero.
    assign misaligned = (dr & XLEN'(STEP - 1)) != '0;

    always_comb begin
        pc_next  = pc + XLEN'(STEP);
        epc_next = epc;
        fault    = 1'b0;
        if (trap) begin
            pc_next  = TRAP_VEC;
            epc_next = pc;
        end else if (eret) begin
            pc_next  = epc;
        end else if (ct_taken) begin
            if (misaligned) begin
                pc_next  = TRAP_VEC;
                epc_next = pc;
                fault    = 1'b1;
            end else begin
                pc_next  = dr;
            end
        end
    end

endmodule

// File: rtl/pc_unit.sv
// pc_unit: program counter with boot/run/halt control, trap entry and return.
//   clk            : clock, all state updates on posedge
//   n_rst          : asynchronous active-low reset
//   phase          : phase vector; only bit PH_N-1 (write-back) is decoded
//   stall          : holds pc/epc during RUN
//   ct_taken, dr   : control transfer request and target
//   trap, eret     : trap entry / return from trap
//   halt_req       : enter HALT after the current update event
//   pc, epc        : registered program counter and saved pc
//   link           : combinational pc + STEP
//   state          : FSM state (BOOT/RUN/HALT)
//   misalign_fault : one-cycle pulse after a misaligned transfer
module pc_unit
    import pc_pkg::*;
#(
    parameter int unsigned     XLEN      = 32,
    parameter int unsigned     PH_N      = PH_N_DEF,
    parameter int unsigned     STEP      = STEP_DEF,
    parameter logic [XLEN-1:0] RESET_VEC = XLEN'(RESET_VEC_DEF),
    parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(TRAP_VEC_DEF)
) (
    input  logic            clk,
    input  logic            n_rst,
    input  logic [PH_N-1:0] phase,
    input  logic            stall,
    input  logic            ct_taken,
    input  logic [XLEN-1:0] dr,
    input  logic            trap,
    input  logic            eret,
    input  logic            halt_req,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] epc,
    output logic [XLEN-1:0] link,
    output logic [1:0]      state,
    output logic            misalign_fault
);

    state_t          state_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] epc_q;
    logic            fault_q;

    logic [XLEN-1:0] pc_next;
    logic [XLEN-1:0] epc_next;
    logic            fault_next;
    logic            update;
    logic            unused_phase;

    // Only the write-back bit matters; the rest of the phase vector is ignored.
    assign unused_phase = ^phase[PH_N-2:0];
    assign update       = (state_q == RUN) && phase[PH_N-1] && !stall;

    pc_next_sel #(
        .XLEN     (XLEN),
        .STEP     (STEP),
        .TRAP_VEC (TRAP_VEC)
    ) u_sel (
        .pc       (pc_q),
        .epc      (epc_q),
        .dr       (dr),
        .trap     (trap),
        .eret     (eret),
        .ct_taken (ct_taken),
        .pc_next  (pc_next),
        .epc_next (epc_next),
        .fault    (fault_next)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pc_q    <= RESET_VEC;
            epc_q   <= '0;
            state_q <= BOOT;
            fault_q <= 1'b0;
        end else begin
            fault_q <= 1'b0;
            case (state_q)
                BOOT: begin
                    pc_q    <= RESET_VEC;
                    state_q <= RUN;
                end
                RUN: begin
                    if (update) begin
                        pc_q    <= pc_next;
                        epc_q   <= epc_next;
                        fault_q <= fault_next;
                        if (halt_req) begin
                            state_q <= HALT;
                        end
                    end
                end
                HALT: begin
                    // Trap wakes the unit regardless of phase and stall.
                    if (trap) begin
                        pc_q    <= TRAP_VEC;
                        epc_q   <= pc_q;
                        state_q <= RUN;
                    end
                end
                default: begin
                    pc_q    <= RESET_VEC;
                    state_q <= BOOT;
                end
            endcase
        end
    end

    assign pc             = pc_q;
    assign epc            = epc_q;
    assign link           = pc_q + XLEN'(STEP);
    assign state          = state_q;
    assign misalign_fault = fault_q;

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: self-checking bench for pc_unit (default parameters).
module tb_pc_unit;

    localparam logic [4:0] WB = 5'b10000;

    logic        clk = 1'b0;
    logic        n_rst;
    logic [4:0]  phase;
    logic        stall, ct_taken, trap, eret, halt_req;
    logic [31:0] dr;
    logic [31:0] pc, epc, link;
    logic [1:0]  state;
    logic        misalign_fault;

    int total = 0;
    int bad   = 0;

    pc_unit dut (
        .clk            (clk),
        .n_rst          (n_rst),
        .phase          (phase),
        .stall          (stall),
        .ct_taken       (ct_taken),
        .dr             (dr),
        .trap           (trap),
        .eret           (eret),
        .halt_req       (halt_req),
        .pc             (pc),
        .epc            (epc),
        .link           (link),
        .state          (state),
        .misalign_fault (misalign_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  ph;
        logic        st;
        logic        ct;
        logic [31:0] d;
        logic        tr;
        logic        er;
        logic        hl;
        logic [31:0] e_pc;
        logic [31:0] e_epc;
        logic [1:0]  e_state;
        logic        e_f;
    } vec_t;

    vec_t tbl[20];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [4:0] ph, input logic st, input logic ct, input logic [31:0] d,
                         input logic tr, input logic er, input logic hl);
        phase = ph; stall = st; ct_taken = ct; dr = d; trap = tr; eret = er; halt_req = hl;
    endtask

    // One clock: apply inputs, take the edge, settle.
    task automatic step(input logic [4:0] ph, input logic st, input logic ct, input logic [31:0] d,
                        input logic tr, input logic er, input logic hl);
        drive(ph, st, ct, d, tr, er, hl);
        @(posedge clk);
        #1;
    endtask

    // Reference model: 0=BOOT 1=RUN 2=HALT
    logic [31:0] m_pc, m_epc;
    int          m_st;
    logic        m_f;

    task automatic model(input logic [4:0] ph, input logic st, input logic ct, input logic [31:0] d,
                         input logic tr, input logic er, input logic hl);
        m_f = 1'b0;
        if (m_st == 0) begin
            m_st = 1;
        end else if (m_st == 2) begin
            if (tr) begin
                m_epc = m_pc; m_pc = 32'h100; m_st = 1;
            end
        end else if (ph[4] && !st) begin
            if (tr) begin
                m_epc = m_pc; m_pc = 32'h100;
            end else if (er) begin
                m_pc = m_epc;
            end else if (ct && (d % 4 == 0)) begin
                m_pc = d;
            end else if (ct) begin
                m_epc = m_pc; m_pc = 32'h100; m_f = 1'b1;
            end else begin
                m_pc = m_pc + 32'd4;
            end
            if (hl) m_st = 2;
        end
    endtask

    initial begin
        n_rst = 1'b0;
        drive(5'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

        // rows: phase stall ct dr trap eret halt | pc epc state fault
        tbl[0]  = '{WB,      0, 1, 32'h40,       0, 0, 0, 32'h40,       32'h0,  2'd1, 0};
        tbl[1]  = '{WB,      0, 1, 32'h200,      0, 0, 0, 32'h200,      32'h0,  2'd1, 0};
        tbl[2]  = '{WB,      1, 1, 32'h500,      0, 0, 0, 32'h200,      32'h0,  2'd1, 0};
        tbl[3]  = '{5'b00001,0, 0, 32'h0,        0, 0, 0, 32'h200,      32'h0,  2'd1, 0};
        tbl[4]  = '{WB,      0, 1, 32'h40,       0, 0, 0, 32'h40,       32'h0,  2'd1, 0};
        tbl[5]  = '{WB,      0, 1, 32'h202,      0, 0, 0, 32'h100,      32'h40, 2'd1, 1};
        tbl[6]  = '{WB,      0, 0, 32'h0,        0, 1, 0, 32'h40,       32'h40, 2'd1, 0};
        tbl[7]  = '{WB,      0, 1, 32'h80,       0, 0, 0, 32'h80,       32'h40, 2'd1, 0};
        tbl[8]  = '{WB,      0, 1, 32'h300,      1, 1, 0, 32'h100,      32'h80, 2'd1, 0};
        tbl[9]  = '{WB,      0, 1, 32'h10,       0, 1, 0, 32'h80,       32'h80, 2'd1, 0};
        tbl[10] = '{WB,      0, 1, 32'h10,       0, 0, 0, 32'h10,       32'h80, 2'd1, 0};
        tbl[11] = '{5'b11111,0, 0, 32'h0,        0, 0, 0, 32'h14,       32'h80, 2'd1, 0};
        tbl[12] = '{WB,      0, 1, 32'hFFFFFFFC, 0, 0, 0, 32'hFFFFFFFC, 32'h80, 2'd1, 0};
        tbl[13] = '{WB,      0, 0, 32'h0,        0, 0, 0, 32'h0,        32'h80, 2'd1, 0};
        tbl[14] = '{WB,      0, 1, 32'h10,       0, 0, 0, 32'h10,       32'h80, 2'd1, 0};
        tbl[15] = '{WB,      0, 0, 32'h0,        0, 0, 1, 32'h14,       32'h80, 2'd2, 0};
        tbl[16] = '{WB,      0, 0, 32'h0,        0, 0, 0, 32'h14,       32'h80, 2'd2, 0};
        tbl[17] = '{5'b00000,1, 0, 32'h0,        1, 0, 0, 32'h100,      32'h14, 2'd1, 0};
        tbl[18] = '{WB,      0, 1, 32'h3,        1, 0, 0, 32'h100,      32'h100,2'd1, 0};
        tbl[19] = '{WB,      0, 1, 32'h3,        0, 0, 0, 32'h100,      32'h100,2'd1, 1};

        // Reset state
        #12;
        chk("rst_pc", pc, 32'h0);
        chk("rst_epc", epc, 32'h0);
        chk("rst_state", {30'd0, state}, 32'd0);
        chk("rst_fault", {31'd0, misalign_fault}, 32'd0);

        // Release, one BOOT clock, then three write-back updates
        @(negedge clk);
        n_rst = 1'b1;
        #1;
        chk("boot_state", {30'd0, state}, 32'd0);
        step(WB, 0, 0, 32'h0, 0, 0, 0);
        chk("boot_exit_state", {30'd0, state}, 32'd1);
        chk("boot_exit_pc", pc, 32'h0);
        for (int i = 1; i <= 3; i++) begin
            step(WB, 0, 0, 32'h0, 0, 0, 0);
            chk($sformatf("seq_pc%0d", i), pc, 32'(4 * i));
        end

        // Vector table
        for (int i = 0; i < 20; i++) begin
            step(tbl[i].ph, tbl[i].st, tbl[i].ct, tbl[i].d, tbl[i].tr, tbl[i].er, tbl[i].hl);
            chk($sformatf("v%0d_pc", i), pc, tbl[i].e_pc);
            chk($sformatf("v%0d_epc", i), epc, tbl[i].e_epc);
            chk($sformatf("v%0d_state", i), {30'd0, state}, {30'd0, tbl[i].e_state});
            chk($sformatf("v%0d_fault", i), {31'd0, misalign_fault}, {31'd0, tbl[i].e_f});
            chk($sformatf("v%0d_link", i), link, tbl[i].e_pc + 32'd4);
        end

        // Asynchronous reset between edges
        step(WB, 0, 1, 32'h300, 0, 0, 0);
        chk("pre_async_pc", pc, 32'h300);
        #3;
        n_rst = 1'b0;
        #1;
        chk("async_pc", pc, 32'h0);
        chk("async_epc", epc, 32'h0);
        chk("async_state", {30'd0, state}, 32'd0);

        // Update requested while reset is held must not land
        step(WB, 0, 0, 32'h0, 1, 0, 0);
        chk("rst_hold_pc", pc, 32'h0);
        chk("rst_hold_epc", epc, 32'h0);
        drive(WB, 0, 0, 32'h0, 0, 0, 0);
        #2;
        n_rst = 1'b1;
        #1;
        chk("rerel_state", {30'd0, state}, 32'd0);
        step(WB, 0, 0, 32'h0, 0, 0, 0);
        chk("reboot_pc", pc, 32'h0);
        chk("reboot_state", {30'd0, state}, 32'd1);

        // Randomized run against the reference model
        m_pc = 32'h0; m_epc = 32'h0; m_st = 1; m_f = 1'b0;
        for (int n = 0; n < 400; n++) begin
            logic [4:0]  r_ph;
            logic        r_st, r_ct, r_tr, r_er, r_hl;
            logic [31:0] r_d;
            r_ph = 5'($urandom);
            r_st = ($urandom_range(0, 3) == 0);
            r_ct = ($urandom_range(0, 2) == 0);
            r_tr = ($urandom_range(0, 15) == 0);
            r_er = ($urandom_range(0, 7) == 0);
            r_hl = ($urandom_range(0, 19) == 0);
            case ($urandom_range(0, 3))
                0:       r_d = $urandom;
                1:       r_d = 32'hFFFFFFFC;
                default: r_d = $urandom & 32'hFFFF_FFFC;
            endcase
            step(r_ph, r_st, r_ct, r_d, r_tr, r_er, r_hl);
            model(r_ph, r_st, r_ct, r_d, r_tr, r_er, r_hl);
            chk($sformatf("r%0d_pc", n), pc, m_pc);
            chk($sformatf("r%0d_epc", n), epc, m_epc);
            chk($sformatf("r%0d_state", n), {30'd0, state}, 32'(m_st));
            chk($sformatf("r%0d_fault", n), {31'd0, misalign_fault}, {31'd0, m_f});
            chk($sformatf("r%0d_link", n), link, m_pc + 32'd4);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
